// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain controller.
// Imported by scan_chain_ctrl and scan_bit_counter.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } scan_state_t;

    localparam int SCAN_CHAIN_LEN_DEFAULT = 16;

endpackage

// File: rtl/scan_bit_counter.sv
// Shift counter for one load/capture pass.
// Saturates at CHAIN_LEN; last flags the final shift.
module scan_bit_counter
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    logic [CW-1:0] count;

    // count shift edges, never past CHAIN_LEN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CW'(CHAIN_LEN))) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain initiator: loads a word MSB-first and captures old contents.
// Optional pause input enabled by defining SCAN_CTRL_PAUSE_EN.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic [CHAIN_LEN-1:0] capture_data,
    output logic                 busy,
    output logic                 done,
    output logic                 scan_enable,
    output logic                 scan_in,
`ifdef SCAN_CTRL_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic                 scan_out
);

    scan_state_t state;
    scan_state_t state_n;

    logic [CHAIN_LEN-1:0] tx;
    logic [CHAIN_LEN-1:0] tx_n;
    logic [CHAIN_LEN-1:0] rx;
    logic [CHAIN_LEN-1:0] rx_n;
    logic                 se_n;
    logic                 si_n;
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 last;
    logic                 hold;

`ifdef SCAN_CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    scan_bit_counter #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .last (last)
    );

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx          <= '0;
            rx          <= '0;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
        end else begin
            state       <= state_n;
            tx          <= tx_n;
            rx          <= rx_n;
            scan_enable <= se_n;
            scan_in     <= si_n;
        end
    end

    // next-state, shift datapath and counter control
    always_comb begin
        state_n   = state;
        tx_n      = tx;
        rx_n      = rx;
        se_n      = scan_enable;
        si_n      = scan_in;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = SHIFT;
                    tx_n      = {load_data[CHAIN_LEN-2:0], 1'b0};
                    rx_n      = '0;
                    se_n      = 1'b1;
                    si_n      = load_data[CHAIN_LEN-1];
                    cnt_clear = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (scan_enable) begin
                    rx_n    = {rx[CHAIN_LEN-2:0], scan_out};
                    cnt_inc = 1'b1;
                    if (last) begin
                        state_n = DONE;
                        se_n    = 1'b0;
                        si_n    = 1'b0;
                    end else begin
                        si_n = tx[CHAIN_LEN-1];
                        tx_n = {tx[CHAIN_LEN-2:0], 1'b0};
                        se_n = !hold;
                    end
                end else begin
                    se_n = !hold;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign capture_data = rx;
    assign busy         = (state == SHIFT);
    assign done         = (state == DONE);

endmodule
